// File: rtl/mdu_pkg.sv
// Shared definitions for the RV32M divide unit: opcode encoding, controller
// states, default datapath width and small opcode decode helpers.
package mdu_pkg;

  localparam int MDU_WIDTH = 32;

  typedef enum logic [1:0] {
    OP_DIV  = 2'b00,
    OP_DIVU = 2'b01,
    OP_REM  = 2'b10,
    OP_REMU = 2'b11
  } mdu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_RESP = 2'b10
  } mdu_state_e;

  // DIV and REM treat their operands as two's complement.
  function automatic logic op_is_signed(input logic [1:0] op);
    return (op == OP_DIV) || (op == OP_REM);
  endfunction

  // REM and REMU return the remainder rather than the quotient.
  function automatic logic op_is_rem(input logic [1:0] op);
    return (op == OP_REM) || (op == OP_REMU);
  endfunction

endpackage

// File: rtl/mdu_div_core.sv
// Iterative unsigned restoring divider. One quotient bit per cycle; done
// pulses WIDTH cycles after start, with q/r presented combinationally in the
// same cycle as done (they are the result of the final iteration).
module mdu_div_core
  import mdu_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r
);

  localparam int CW = $clog2(WIDTH + 1);

  logic             busy_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;

  // One restoring step: shift in the next dividend bit, try to subtract.
  // NOTE: every signal written here gets a value before any branch, so no latch is inferred.
  always_comb begin
    shifted = {r_q, q_q[WIDTH-1]};
    trial   = shifted - {1'b0, b_q};
    q       = {q_q[WIDTH-2:0], ~trial[WIDTH]};
    r       = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
    done    = busy_q && (cnt_q == CW'(WIDTH - 1));
  end

  // Iteration control: count WIDTH steps after start.
  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
    end else if (start) begin
      busy_q <= 1'b1;
      cnt_q  <= '0;
    end else if (busy_q) begin
      if (done) busy_q <= 1'b0;
      cnt_q <= cnt_q + CW'(1);
    end
  end

  // Partial quotient/remainder shift registers.
  // NOTE: datapath registers carry no reset; their contents only matter while a reset control bit says so.
  always_ff @(posedge clk) begin
    if (start) begin
      q_q <= a;
      r_q <= '0;
      b_q <= b;
    end else if (busy_q) begin
      q_q <= q;
      r_q <= r;
    end
  end

endmodule

// File: rtl/mdu_div_arb.sv
// Two-port RV32M divide controller: round-robin arbitration, sign
// conditioning around a shared unsigned core, one-cycle special cases and a
// one-entry result cache for DIV/REM pairs on identical operands.
module mdu_div_arb
  import mdu_pkg::*;
#(
  parameter int WIDTH    = MDU_WIDTH,
  parameter bit CACHE_EN = 1'b1
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             req0_valid,
  input  logic [1:0]       req0_op,
  input  logic [WIDTH-1:0] req0_rs1,
  input  logic [WIDTH-1:0] req0_rs2,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [1:0]       req1_op,
  input  logic [WIDTH-1:0] req1_rs1,
  input  logic [WIDTH-1:0] req1_rs2,
  output logic             req1_ready,
  output logic             rsp0_valid,
  output logic [WIDTH-1:0] rsp0_data,
  output logic             rsp1_valid,
  output logic [WIDTH-1:0] rsp1_data
);

  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  mdu_state_e       state_q, state_d;
  logic             last_q;
  logic             owner_q;
  logic             start_q;
  logic             grant;
  logic             accept;
  logic             fast;

  logic [1:0]       acc_op;
  logic [WIDTH-1:0] acc_rs1, acc_rs2;
  logic             acc_signed, acc_rem;
  logic             div_zero, sgn_ovf, cache_hit;
  logic [WIDTH-1:0] fast_data;
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] mag_a, mag_b;

  logic [1:0]       op_q;
  logic [WIDTH-1:0] rs1_q, rs2_q, mag_a_q, mag_b_q;
  logic             qneg_q, rneg_q;
  logic [WIDTH-1:0] result_q;

  logic             cache_valid_q, cache_signed_q;
  logic [WIDTH-1:0] cache_rs1_q, cache_rs2_q, cache_q_q, cache_r_q;

  logic             core_done;
  logic [WIDTH-1:0] core_q, core_r;
  logic [WIDTH-1:0] q_fin, r_fin;

  // Round-robin grant: a lone requester wins, a tie goes to the port not
  // granted last. last_q resets to 1 so port 0 wins the first tie.
  always_comb begin
    grant = 1'b0;
    if (req0_valid && req1_valid) grant = ~last_q;
    else if (req1_valid)          grant = 1'b1;
  end

  // Operands of the granted port plus sign conditioning for the core.
  always_comb begin
    acc_op     = grant ? req1_op  : req0_op;
    acc_rs1    = grant ? req1_rs1 : req0_rs1;
    acc_rs2    = grant ? req1_rs2 : req0_rs2;
    acc_signed = op_is_signed(acc_op);
    acc_rem    = op_is_rem(acc_op);
    a_neg      = acc_signed && acc_rs1[WIDTH-1];
    b_neg      = acc_signed && acc_rs2[WIDTH-1];
    mag_a      = a_neg ? -acc_rs1 : acc_rs1;
    mag_b      = b_neg ? -acc_rs2 : acc_rs2;
  end

  // Single-cycle cases: divide by zero, signed overflow, cache hit.
  always_comb begin
    div_zero  = (acc_rs2 == '0);
    sgn_ovf   = acc_signed && (acc_rs1 == MIN_VAL) && (acc_rs2 == '1);
    cache_hit = CACHE_EN && cache_valid_q && (cache_rs1_q == acc_rs1) &&
                (cache_rs2_q == acc_rs2) && (cache_signed_q == acc_signed);
    fast      = div_zero || sgn_ovf || cache_hit;
    if (div_zero)     fast_data = acc_rem ? acc_rs1 : '1;
    else if (sgn_ovf) fast_data = acc_rem ? '0 : acc_rs1;
    else              fast_data = acc_rem ? cache_r_q : cache_q_q;
  end

  // FSM next state and port handshakes. Ready is held low during reset.
  always_comb begin
    state_d    = state_q;
    req0_ready = resetn && (state_q == ST_IDLE) && !grant;
    req1_ready = resetn && (state_q == ST_IDLE) && grant;
    accept     = (req0_valid && req0_ready) || (req1_valid && req1_ready);
    rsp0_valid = (state_q == ST_RESP) && !owner_q;
    rsp1_valid = (state_q == ST_RESP) && owner_q;
    rsp0_data  = rsp0_valid ? result_q : '0;
    rsp1_data  = rsp1_valid ? result_q : '0;
    unique case (state_q)
      ST_IDLE: if (accept) state_d = fast ? ST_RESP : ST_RUN;
      ST_RUN:  if (core_done) state_d = ST_RESP;
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Control state: FSM, arbitration pointer, core start pulse, cache valid.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q       <= ST_IDLE;
      last_q        <= 1'b1;
      owner_q       <= 1'b0;
      start_q       <= 1'b0;
      cache_valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      start_q <= accept && !fast;
      if (accept) begin
        last_q  <= grant;
        owner_q <= grant;
      end
      if (CACHE_EN && (state_q == ST_RUN) && core_done) cache_valid_q <= 1'b1;
    end
  end

  assign q_fin = qneg_q ? -core_q : core_q;
  assign r_fin = rneg_q ? -core_r : core_r;

  // Operation context, result register and cache payload.
  always_ff @(posedge clk) begin
    if (accept && fast) result_q <= fast_data;
    if (accept && !fast) begin
      op_q    <= acc_op;
      rs1_q   <= acc_rs1;
      rs2_q   <= acc_rs2;
      mag_a_q <= mag_a;
      mag_b_q <= mag_b;
      qneg_q  <= acc_signed && (acc_rs1[WIDTH-1] != acc_rs2[WIDTH-1]);
      rneg_q  <= a_neg;
    end
    if ((state_q == ST_RUN) && core_done) begin
      result_q <= op_is_rem(op_q) ? r_fin : q_fin;
      if (CACHE_EN) begin
        cache_rs1_q    <= rs1_q;
        cache_rs2_q    <= rs2_q;
        cache_signed_q <= op_is_signed(op_q);
        cache_q_q      <= q_fin;
        cache_r_q      <= r_fin;
      end
    end
  end

  mdu_div_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .clk    (clk),
    .resetn (resetn),
    .start  (start_q),
    .a      (mag_a_q),
    .b      (mag_b_q),
    .done   (core_done),
    .q      (core_q),
    .r      (core_r)
  );

endmodule
